vote_tally_engine: RTL and testbench
====================================

Name: vote_tally_engine

Overview:
Parametrised N-candidate vote tally with poll open/close control, per-vote accept/reject acknowledgement, saturating counters, and a sequential winner-scan FSM with tie detection. It sits behind the ballot front-end, which delivers one-cycle valid_vote strobes. It returns the winner and totals to the result/display logic through a request/busy/available handshake. A registered read port gives per-candidate counts for audit.

Parameters:
NUM_CAND, 8, number of candidates; legal range 2..16.
CAND_W, 4, width of candidate/ID fields; 2**CAND_W >= NUM_CAND.
CNT_W, 16, width of every vote counter.

Ports:
clk  in  1  system clock, all logic on rising edge
reset  in  1  synchronous active-high reset
open_poll  in  1  pulse: open poll (CLOSED->OPEN), clears tallies and results
close_poll  in  1  pulse: close poll (OPEN->CLOSED)
valid_vote  in  1  one-cycle vote strobe
candidate  in  CAND_W  candidate index for valid_vote
vote_ack  out  1  registered pulse: vote counted
vote_reject  out  1  registered pulse: vote refused
poll_open  out  1  1 while in OPEN
result_request  in  1  pulse: start winner scan
result_busy  out  1  1 while scan in progress
results_available  out  1  level: winner outputs valid
total_votes_cast  out  CNT_W  accepted votes, saturating
rejected_votes  out  CNT_W  refused votes, saturating
winning_candidate_id  out  CAND_W  lowest index holding max count
winning_candidate_votes  out  CNT_W  max count
tie  out  1  >=2 candidates share max count
read_addr  in  CAND_W  audit read index
read_count  out  CNT_W  registered count of read_addr

Behaviour:
- Reset: every output is 0. Poll = CLOSED. Scan FSM = S_IDLE. All tallies = 0. Reset mid-scan aborts the scan with no result.
- Poll FSM CLOSED/OPEN:
  - open_poll is honoured only in CLOSED with result_busy=0. It clears tallies, totals, rejected_votes, winner outputs, tie and results_available, then enters OPEN.
  - close_poll in OPEN -> CLOSED.
  - open_poll or close_poll in any other state is ignored.
- Vote handling:
  - A vote is decoded against the state before any same-edge poll transition. A vote in the close_poll cycle is therefore evaluated as OPEN. A vote in the open_poll cycle is evaluated as CLOSED.
  - Accept when: OPEN, candidate < NUM_CAND, votes[candidate] != all-ones, and total_votes_cast != all-ones.
  - On accept: votes[candidate]+1 and total_votes_cast+1. vote_ack=1 on the next cycle.
  - Otherwise: rejected_votes+1, saturating at all-ones. vote_reject=1 on the next cycle.
  - For every valid_vote, exactly one of vote_ack/vote_reject pulses. Without valid_vote, neither pulses.
- Scan FSM S_IDLE/S_SCAN/S_DONE:
  - result_request is honoured only in S_IDLE with poll CLOSED. Otherwise it is ignored (no busy, no available change).
  - Accept edge E0:
    - results_available cleared.
    - result_busy=1.
    - best_id=0, best=votes[0], idx=1, tie_r=0.
    - Go to S_SCAN.
  - S_SCAN, one candidate per cycle:
    - votes[idx] > best: best, best_id updated, tie_r=0.
    - votes[idx] == best: tie_r=1, best_id unchanged.
    - After idx = NUM_CAND-1 -> S_DONE.
  - S_DONE:
    - Register best_id, best and tie_r onto the outputs.
    - results_available=1, result_busy=0.
    - Return to S_IDLE.
  - Latency: results_available rises NUM_CAND cycles after E0 (8 at default).
  - All-zero tally: id 0, votes 0, tie=1.
- results_available and the winner outputs hold until the next honoured result_request, an honoured open_poll, or reset.
- Counts are stable during a scan because the poll is CLOSED.
- read_count <= votes[read_addr] every cycle, 1-cycle latency. It reads 0 when read_addr >= NUM_CAND. The read port works in any state.

Test Plan:
1. Reset, open_poll, votes 2,2,5,0,2, close_poll, result_request -> 5 ack pulses; total=5; id=2, votes=3, tie=0; results_available exactly 8 cycles after request; result_busy high 8 cycles.
2. Votes 1,3,3,1, close, request -> id=1, votes=2, tie=1. No votes after open, request -> id=0, votes=0, tie=1.
3. While CLOSED, vote cand 1 -> vote_reject, rejected_votes=1, no count change. While OPEN, candidate=9 (NUM_CAND=8) -> vote_reject. Vote in the same cycle as close_poll -> vote_ack.
4. CNT_W=3: 8 votes to cand 4 -> 7 acks then 1 reject; votes[4]=7, total=7, rejected=1.
5. result_request while OPEN -> ignored, busy stays 0. Second request mid-scan -> ignored, single result. open_poll mid-scan -> ignored, scan completes.
6. reset asserted mid-scan -> next cycle all outputs 0, FSMs idle. read_addr=3 after 4 votes to cand 3 -> read_count=4 one cycle later; read_addr=12 -> 0.

Source files
------------

// File: rtl/vote_tally_engine.sv
`default_nettype none
// ============================================================================
// Module      : vote_tally_engine
// Description : N-candidate vote tally with poll control, saturating counts,
//               sequential winner scan with tie detection and audit read port.
// Revision    : 1.0 - initial release
// ============================================================================
module vote_tally_engine #(
    parameter int NUM_CAND = 8,
    parameter int CAND_W   = 4,
    parameter int CNT_W    = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              open_poll,
    input  logic              close_poll,
    input  logic              valid_vote,
    input  logic [CAND_W-1:0] candidate,
    output logic              vote_ack,
    output logic              vote_reject,
    output logic              poll_open,
    input  logic              result_request,
    output logic              result_busy,
    output logic              results_available,
    output logic [CNT_W-1:0]  total_votes_cast,
    output logic [CNT_W-1:0]  rejected_votes,
    output logic [CAND_W-1:0] winning_candidate_id,
    output logic [CNT_W-1:0]  winning_candidate_votes,
    output logic              tie,
    input  logic [CAND_W-1:0] read_addr,
    output logic [CNT_W-1:0]  read_count
);

    localparam logic [CAND_W:0]   c_num_cand = (CAND_W + 1)'(NUM_CAND);
    localparam logic [CAND_W-1:0] c_last_idx = CAND_W'(NUM_CAND - 1);
    localparam logic [CNT_W-1:0]  c_cnt_max  = '1;

    typedef enum logic [0:0] {POLL_CLOSED = 1'b0, POLL_OPEN = 1'b1} poll_t;
    typedef enum logic [1:0] {S_IDLE = 2'd0, S_SCAN = 2'd1, S_DONE = 2'd2} scan_t;

    poll_t r_poll, w_poll_next;
    scan_t r_scan, w_scan_next;

    logic [CNT_W-1:0]  r_votes [NUM_CAND];
    logic [CNT_W-1:0]  r_total, r_rejected, r_best, r_win_votes, r_read_count;
    logic [CAND_W-1:0] r_idx, r_best_id, r_win_id;
    logic              r_tie, r_win_tie, r_ack, r_reject, r_busy, r_avail;

    logic              w_open_ok, w_close_ok, w_req_ok;
    logic              w_cand_ok, w_cand_full, w_accept, w_reject;
    logic [CNT_W-1:0]  w_scan_val, w_read_val;

    // Handshake qualifiers use the current state so same-edge transitions
    // never influence vote decoding.
    assign w_open_ok  = open_poll && (r_poll == POLL_CLOSED) && !r_busy;
    assign w_close_ok = close_poll && (r_poll == POLL_OPEN);
    assign w_req_ok   = result_request && (r_scan == S_IDLE) && (r_poll == POLL_CLOSED);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_poll <= POLL_CLOSED;
            r_scan <= S_IDLE;
        end else begin
            r_poll <= w_poll_next;
            r_scan <= w_scan_next;
        end
    end

    always_comb begin
        w_poll_next = r_poll;
        if (w_open_ok) begin
            w_poll_next = POLL_OPEN;
        end else if (w_close_ok) begin
            w_poll_next = POLL_CLOSED;
        end
    end

    always_comb begin
        w_scan_next = r_scan;
        case (r_scan)
            S_IDLE:  if (w_req_ok) w_scan_next = S_SCAN;
            S_SCAN:  if (r_idx == c_last_idx) w_scan_next = S_DONE;
            S_DONE:  w_scan_next = S_IDLE;
            default: w_scan_next = S_IDLE;
        endcase
    end

    always_comb begin
        w_cand_full = 1'b0;
        w_scan_val  = '0;
        w_read_val  = '0;
        for (int k = 0; k < NUM_CAND; k++) begin
            if ((candidate == CAND_W'(k)) && (r_votes[k] == c_cnt_max)) w_cand_full = 1'b1;
            if (r_idx == CAND_W'(k))     w_scan_val = r_votes[k];
            if (read_addr == CAND_W'(k)) w_read_val = r_votes[k];
        end
    end

    assign w_cand_ok = ({1'b0, candidate} < c_num_cand);
    assign w_accept  = valid_vote && (r_poll == POLL_OPEN) && w_cand_ok
                       && !w_cand_full && (r_total != c_cnt_max);
    assign w_reject  = valid_vote && !w_accept;

    always_ff @(posedge clk) begin
        for (int k = 0; k < NUM_CAND; k++) begin
            if (reset || w_open_ok) begin
                r_votes[k] <= '0;
            end else if (w_accept && (candidate == CAND_W'(k))) begin
                r_votes[k] <= r_votes[k] + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_ack        <= 1'b0;
            r_reject     <= 1'b0;
            r_total      <= '0;
            r_rejected   <= '0;
            r_busy       <= 1'b0;
            r_avail      <= 1'b0;
            r_idx        <= '0;
            r_best       <= '0;
            r_best_id    <= '0;
            r_tie        <= 1'b0;
            r_win_id     <= '0;
            r_win_votes  <= '0;
            r_win_tie    <= 1'b0;
            r_read_count <= '0;
        end else begin
            r_ack        <= w_accept;
            r_reject     <= w_reject;
            r_read_count <= w_read_val;

            if (w_open_ok) begin
                r_total     <= '0;
                r_rejected  <= '0;
                r_win_id    <= '0;
                r_win_votes <= '0;
                r_win_tie   <= 1'b0;
                r_avail     <= 1'b0;
            end else begin
                if (w_accept) r_total <= r_total + CNT_W'(1);
                if (w_reject && (r_rejected != c_cnt_max)) r_rejected <= r_rejected + CNT_W'(1);
            end

            case (r_scan)
                S_IDLE: begin
                    if (w_req_ok) begin
                        r_avail   <= 1'b0;
                        r_busy    <= 1'b1;
                        r_best_id <= '0;
                        r_best    <= r_votes[0];
                        r_idx     <= CAND_W'(1);
                        r_tie     <= 1'b0;
                    end
                end
                S_SCAN: begin
                    // Strict > keeps the lowest index on equal counts.
                    if (w_scan_val > r_best) begin
                        r_best    <= w_scan_val;
                        r_best_id <= r_idx;
                        r_tie     <= 1'b0;
                    end else if (w_scan_val == r_best) begin
                        r_tie <= 1'b1;
                    end
                    r_idx <= r_idx + CAND_W'(1);
                end
                S_DONE: begin
                    r_win_id    <= r_best_id;
                    r_win_votes <= r_best;
                    r_win_tie   <= r_tie;
                    r_avail     <= 1'b1;
                    r_busy      <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign vote_ack                = r_ack;
    assign vote_reject             = r_reject;
    assign poll_open               = (r_poll == POLL_OPEN);
    assign result_busy             = r_busy;
    assign results_available       = r_avail;
    assign total_votes_cast        = r_total;
    assign rejected_votes          = r_rejected;
    assign winning_candidate_id    = r_win_id;
    assign winning_candidate_votes = r_win_votes;
    assign tie                     = r_win_tie;
    assign read_count              = r_read_count;

endmodule
`default_nettype wire

// File: tb/tb_vote_tally_engine.sv
`default_nettype none
// ============================================================================
// Module      : tb_vote_tally_engine
// Description : Directed + random bench; a 16-bit and a 3-bit counter instance
//               share stimulus and are each tracked by a plain tally model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_vote_tally_engine;

    localparam int NC   = 8;
    localparam int MAXA = 65535;
    localparam int MAXB = 7;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset, open_poll, close_poll, valid_vote, result_request;
    logic [3:0] candidate, read_addr;

    logic        a_ack, a_rej, a_open, a_busy, a_avail, a_tie;
    logic [15:0] a_total, a_rejc, a_wv, a_rc;
    logic [3:0]  a_wid;
    logic        b_ack, b_rej, b_open, b_busy, b_avail, b_tie;
    logic [2:0]  b_total, b_rejc, b_wv, b_rc;
    logic [3:0]  b_wid;

    vote_tally_engine #(.NUM_CAND(8), .CAND_W(4), .CNT_W(16)) dut_a (
        .clk(clk), .reset(reset), .open_poll(open_poll), .close_poll(close_poll),
        .valid_vote(valid_vote), .candidate(candidate), .vote_ack(a_ack),
        .vote_reject(a_rej), .poll_open(a_open), .result_request(result_request),
        .result_busy(a_busy), .results_available(a_avail), .total_votes_cast(a_total),
        .rejected_votes(a_rejc), .winning_candidate_id(a_wid),
        .winning_candidate_votes(a_wv), .tie(a_tie), .read_addr(read_addr),
        .read_count(a_rc)
    );

    vote_tally_engine #(.NUM_CAND(8), .CAND_W(4), .CNT_W(3)) dut_b (
        .clk(clk), .reset(reset), .open_poll(open_poll), .close_poll(close_poll),
        .valid_vote(valid_vote), .candidate(candidate), .vote_ack(b_ack),
        .vote_reject(b_rej), .poll_open(b_open), .result_request(result_request),
        .result_busy(b_busy), .results_available(b_avail), .total_votes_cast(b_total),
        .rejected_votes(b_rejc), .winning_candidate_id(b_wid),
        .winning_candidate_votes(b_wv), .tie(b_tie), .read_addr(read_addr),
        .read_count(b_rc)
    );

    int total_cnt = 0;
    int bad_cnt   = 0;

    typedef int cnt_t [NC];
    cnt_t cnt_a, cnt_b;
    int   tot_a, tot_b, rej_a, rej_b;
    bit   m_open;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        assert (obs === exp) else begin
            bad_cnt++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_clear();
        for (int i = 0; i < NC; i++) begin
            cnt_a[i] = 0;
            cnt_b[i] = 0;
        end
        tot_a = 0; tot_b = 0; rej_a = 0; rej_b = 0;
    endtask

    // Winner = first index holding the maximum; tie when the maximum occurs twice or more.
    task automatic winner(input cnt_t c, output int id, output int mx, output int t);
        int n;
        mx = c[0];
        id = 0;
        for (int i = 1; i < NC; i++) if (c[i] > mx) begin mx = c[i]; id = i; end
        n = 0;
        for (int i = 0; i < NC; i++) if (c[i] == mx) n++;
        t = (n >= 2) ? 1 : 0;
    endtask

    task automatic vote_ctl(input int c, input bit with_close);
        bit acc_a, acc_b;
        acc_a = 0;
        acc_b = 0;
        if (m_open && c < NC) begin
            acc_a = (cnt_a[c] < MAXA) && (tot_a < MAXA);
            acc_b = (cnt_b[c] < MAXB) && (tot_b < MAXB);
        end
        valid_vote = 1'b1;
        candidate  = 4'(c);
        close_poll = with_close;
        tick();
        valid_vote = 1'b0;
        close_poll = 1'b0;
        if (with_close) m_open = 0;
        if (acc_a) begin cnt_a[c]++; tot_a++; end else if (rej_a < MAXA) rej_a++;
        if (acc_b) begin cnt_b[c]++; tot_b++; end else if (rej_b < MAXB) rej_b++;
        chk("ack_rej_a", {30'd0, a_ack, a_rej}, acc_a ? 2 : 1);
        chk("ack_rej_b", {30'd0, b_ack, b_rej}, acc_b ? 2 : 1);
        chk("total_a", a_total, tot_a);
        chk("total_b", b_total, tot_b);
        chk("rejected_a", a_rejc, rej_a);
        chk("rejected_b", b_rejc, rej_b);
    endtask

    task automatic vote(input int c);
        vote_ctl(c, 1'b0);
    endtask

    task automatic do_open();
        open_poll = 1'b1;
        tick();
        open_poll = 1'b0;
        m_open = 1;
        model_clear();
        chk("open_poll_a", a_open, 1);
        chk("open_poll_b", b_open, 1);
        chk("open_clears_avail", {a_avail, b_avail, a_tie}, 0);
        chk("open_clears_totals", a_total | a_rejc | a_wv, 0);
    endtask

    task automatic do_close();
        close_poll = 1'b1;
        tick();
        close_poll = 1'b0;
        m_open = 0;
        chk("close_poll_a", a_open, 0);
        chk("close_poll_b", b_open, 0);
    endtask

    task automatic do_scan(input bit inject);
        int id_a, mx_a, t_a, id_b, mx_b, t_b, cyc, busy_n;
        winner(cnt_a, id_a, mx_a, t_a);
        winner(cnt_b, id_b, mx_b, t_b);
        result_request = 1'b1;
        tick();
        result_request = 1'b0;
        chk("busy_after_req", a_busy, 1);
        chk("avail_after_req", {a_avail, b_avail}, 0);
        busy_n = a_busy;
        cyc = 0;
        while (cyc < 20) begin
            if (inject && cyc == 2) begin
                result_request = 1'b1;
                open_poll      = 1'b1;
            end
            tick();
            cyc++;
            result_request = 1'b0;
            open_poll      = 1'b0;
            if (a_avail) break;
            busy_n += a_busy;
        end
        chk("scan_latency", cyc, NC);
        chk("busy_cycles", busy_n, NC);
        chk("busy_done", {a_busy, b_busy}, 0);
        chk("avail_b", b_avail, 1);
        chk("win_id_a", a_wid, id_a);
        chk("win_votes_a", a_wv, mx_a);
        chk("tie_a", a_tie, t_a);
        chk("win_id_b", b_wid, id_b);
        chk("win_votes_b", b_wv, mx_b);
        chk("tie_b", b_tie, t_b);
        if (inject) begin
            repeat (3) tick();
            chk("single_result", {a_busy, a_avail, a_open}, 3'b010);
            chk("mid_scan_open_ignored", b_open, 0);
        end
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_flags"}, {a_ack, a_rej, a_open, a_busy, a_avail, a_tie,
                              b_ack, b_rej, b_open, b_busy, b_avail, b_tie}, 0);
        chk({tag, "_a"}, {a_total | a_rejc | a_wv | a_rc, 12'd0, a_wid}, 0);
        chk({tag, "_b"}, {b_total | b_rejc | b_wv | b_rc, 25'd0, b_wid}, 0);
    endtask

    initial begin
        int r, c;
        reset = 1'b1; open_poll = 1'b0; close_poll = 1'b0; valid_vote = 1'b0;
        result_request = 1'b0; candidate = '0; read_addr = '0;
        m_open = 0;
        model_clear();
        repeat (2) tick();
        reset = 1'b0;
        check_all_zero("reset");

        // Basic tally and winner
        do_open();
        vote(2); vote(2); vote(5); vote(0); vote(2);
        do_close();
        do_scan(1'b0);

        // Votes refused while closed
        vote(1);

        // Tie and all-zero tally
        do_open();
        vote(1); vote(3); vote(3); vote(1);
        do_close();
        do_scan(1'b0);
        do_open();
        do_close();
        do_scan(1'b0);

        // Out-of-range candidate; vote coincident with close still counts
        do_open();
        vote(9);
        vote_ctl(5, 1'b1);
        chk("closed_after_vote_close", a_open, 0);

        // Saturation on the 3-bit instance
        do_open();
        repeat (8) vote(4);
        read_addr = 4'd4;
        tick();
        chk("sat_read_b", b_rc, 7);
        chk("sat_read_a", a_rc, 8);
        do_close();
        do_scan(1'b0);

        // Ignored requests
        do_open();
        result_request = 1'b1;
        tick();
        result_request = 1'b0;
        chk("req_open_busy", a_busy, 0);
        tick();
        chk("req_open_ignored", {a_busy, a_avail}, 0);
        vote(6);
        do_close();
        do_scan(1'b1);

        // Audit read port
        do_open();
        repeat (4) vote(3);
        read_addr = 4'd3;
        tick();
        chk("read_3_a", a_rc, 4);
        chk("read_3_b", b_rc, 4);
        read_addr = 4'd12;
        tick();
        chk("read_12", {a_rc, 13'd0, b_rc}, 0);
        do_close();

        // Reset aborts a scan
        result_request = 1'b1;
        tick();
        result_request = 1'b0;
        repeat (3) tick();
        reset = 1'b1;
        read_addr = 4'd0;
        tick();
        reset = 1'b0;
        m_open = 0;
        model_clear();
        check_all_zero("reset_mid_scan");
        repeat (10) tick();
        chk("no_result_after_abort", {a_busy, a_avail, b_busy, b_avail}, 0);

        // Random voting
        do_open();
        for (int n = 0; n < 300; n++) begin
            r = $urandom_range(0, 15);
            if (r < 2) begin
                tick();
                chk("idle_no_pulse", {a_ack, a_rej, b_ack, b_rej}, 0);
            end else begin
                c = (r < 11) ? $urandom_range(0, 3) : $urandom_range(0, 9);
                vote(c);
            end
        end
        do_close();
        do_scan(1'b0);
        for (int k = 0; k < 16; k++) begin
            read_addr = 4'(k);
            tick();
            chk("rand_read_a", a_rc, (k < NC) ? cnt_a[k] : 0);
            chk("rand_read_b", b_rc, (k < NC) ? cnt_b[k] : 0);
        end

        $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
        $finish;
    end

endmodule
`default_nettype wire
